// File: rtl/lock_pkg.sv
// Shared constants, key codes and state encoding for the lock entry controller.
package lock_pkg;

  localparam int unsigned DIG_W   = 4;
  localparam int unsigned N_DIG   = 4;
  localparam int unsigned CNT_SAT = 9;

  localparam logic [DIG_W-1:0] KEY_ENTER  = 4'hA;
  localparam logic [DIG_W-1:0] KEY_CLEAR  = 4'hB;
  localparam logic [DIG_W-1:0] KEY_CHANGE = 4'hC;
  localparam logic [DIG_W-1:0] BLANK      = 4'hF;

  typedef enum logic [2:0] {
    ENTRY  = 3'd0,
    CHECK  = 3'd1,
    OPEN   = 3'd2,
    LOCKED = 3'd3,
    SET    = 3'd4
  } state_e;

  function automatic logic is_digit(input logic [DIG_W-1:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that stops at zero; shared by the OPEN and LOCKED windows.
module lock_timer #(
  parameter int unsigned TMR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             en,
  output logic             zero_c
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/lock_entry_ctrl.sv
// Password-entry controller: digit capture, compare, wrong-attempt lockout.
// Define LOCK_PWD_CHANGE_EN to allow changing the password from OPEN.
module lock_entry_ctrl
  import lock_pkg::*;
#(
  parameter logic [15:0] PWD            = 16'h1234,
  parameter int unsigned MAX_WRONG      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 100_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000,
  parameter int unsigned TMR_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [DIG_W-1:0] key_code,
  output logic [DIG_W-1:0] seg_1,
  output logic [DIG_W-1:0] seg_2,
  output logic [DIG_W-1:0] seg_3,
  output logic [DIG_W-1:0] seg_4,
  output logic [3:0]       count_wrong,
  output logic             unlock,
  output logic             alarm,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [DIG_W-1:0] dig_q [N_DIG];
  logic [DIG_W-1:0] dig_d [N_DIG];
  logic [2:0]       n_q, n_d;
  logic [3:0]       cw_q, cw_d;
  logic             unlock_q, alarm_q, busy_q;
  logic [15:0]      pwd;
  logic [15:0]      entered;
  logic             key_digit;
  logic             tmr_load, tmr_en, tmr_zero;
  logic [TMR_W-1:0] tmr_val;

`ifdef LOCK_PWD_CHANGE_EN
  logic [15:0] pwd_q, pwd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwd_q <= PWD;
    else        pwd_q <= pwd_d;
  end
  assign pwd = pwd_q;
`else
  assign pwd = PWD;
`endif

  assign entered   = {dig_q[0], dig_q[1], dig_q[2], dig_q[3]};
  assign key_digit = key_valid && is_digit(key_code);

  lock_timer #(.TMR_W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero_c   (tmr_zero)
  );

  // Next-state, digit buffer, attempt counter and timer control.
  always_comb begin
    state_d  = state_q;
    dig_d    = dig_q;
    n_d      = n_q;
    cw_d     = cw_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
`ifdef LOCK_PWD_CHANGE_EN
    pwd_d    = pwd_q;
`endif
    case (state_q)
`ifdef LOCK_PWD_CHANGE_EN
      ENTRY, SET: begin
`else
      ENTRY: begin
`endif
        if (key_digit && (n_q < 3'd4)) begin
          dig_d[n_q[1:0]] = key_code;
          n_d             = n_q + 3'd1;
        end else if (key_valid && (key_code == KEY_CLEAR)) begin
          dig_d = '{default: BLANK};
          n_d   = '0;
        end else if (key_valid && (key_code == KEY_ENTER) && (n_q == 3'd4)) begin
`ifdef LOCK_PWD_CHANGE_EN
          if (state_q == SET) begin
            pwd_d   = entered;
            dig_d   = '{default: BLANK};
            n_d     = '0;
            state_d = ENTRY;
          end else begin
            state_d = CHECK;
          end
`else
          state_d = CHECK;
`endif
        end
      end
      CHECK: begin
        dig_d = '{default: BLANK};
        n_d   = '0;
        if (entered == pwd) begin
          cw_d     = '0;
          state_d  = OPEN;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(UNLOCK_CYCLES - 1);
        end else begin
          cw_d = (cw_q >= 4'(CNT_SAT)) ? 4'(CNT_SAT) : cw_q + 4'd1;
          if (cw_d == 4'(MAX_WRONG)) begin
            state_d  = LOCKED;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = ENTRY;
          end
        end
      end
      OPEN: begin
        tmr_en = 1'b1;
`ifdef LOCK_PWD_CHANGE_EN
        if (key_valid && (key_code == KEY_CHANGE)) begin
          tmr_en  = 1'b0;
          state_d = SET;
        end else if (tmr_zero) begin
          state_d = ENTRY;
        end
`else
        if (tmr_zero) state_d = ENTRY;
`endif
      end
      LOCKED: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          cw_d    = '0;
          state_d = ENTRY;
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  // Status outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ENTRY;
      dig_q    <= '{default: BLANK};
      n_q      <= '0;
      cw_q     <= '0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dig_q    <= dig_d;
      n_q      <= n_d;
      cw_q     <= cw_d;
      unlock_q <= (state_d == OPEN) || (state_d == SET);
      alarm_q  <= (state_d == LOCKED);
      busy_q   <= (state_d == CHECK) || (state_d == OPEN) || (state_d == LOCKED);
    end
  end

  assign seg_1       = dig_q[0];
  assign seg_2       = dig_q[1];
  assign seg_3       = dig_q[2];
  assign seg_4       = dig_q[3];
  assign count_wrong = cw_q;
  assign unlock      = unlock_q;
  assign alarm       = alarm_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Scoreboard bench for lock_entry_ctrl; observed word is {segs, count_wrong, unlock, alarm, busy}.
module tb_lock_entry_ctrl;

  localparam int unsigned UNL = 20;
  localparam int unsigned LCK = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] seg_1, seg_2, seg_3, seg_4, count_wrong;
  logic       unlock, alarm, busy;

  int total = 0;
  int passed = 0;
  logic [22:0] exp_q [$];
  logic [22:0] exp_v;
  logic [22:0] obs;

  assign obs = {seg_1, seg_2, seg_3, seg_4, count_wrong, unlock, alarm, busy};

  lock_entry_ctrl #(.UNLOCK_CYCLES(UNL), .LOCKOUT_CYCLES(LCK)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .seg_1(seg_1), .seg_2(seg_2), .seg_3(seg_3), .seg_4(seg_4),
    .count_wrong(count_wrong), .unlock(unlock), .alarm(alarm), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] mk(input logic [15:0] s, input logic [3:0] c,
                                     input logic u, input logic a, input logic b);
    return {s, c, u, a, b};
  endfunction

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(mk(16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL reset_hold: got %h want %h", obs, exp_v); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(mk(16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL reset_release: got %h want %h", obs, exp_v); else passed++;
  endtask

  task automatic test_unlock;
    int cnt;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    exp_q.push_back(mk(16'h1234, 4'd0, 1'b0, 1'b0, 1'b0));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL unlock_digits: got %h want %h", obs, exp_v); else passed++;
    press(4'hA);
    exp_q.push_back(mk(16'h1234, 4'd0, 1'b0, 1'b0, 1'b1));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL unlock_check_cycle: got %h want %h", obs, exp_v); else passed++;
    @(negedge clk);
    exp_q.push_back(mk(16'hFFFF, 4'd0, 1'b1, 1'b0, 1'b1));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL unlock_rise: got %h want %h", obs, exp_v); else passed++;
    cnt = 0;
    while (unlock === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    total++;
    if (cnt !== int'(UNL)) $display("FAIL unlock_width: got %0d want %0d", cnt, UNL); else passed++;
    exp_q.push_back(mk(16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL unlock_done: got %h want %h", obs, exp_v); else passed++;
  endtask

  task automatic test_lockout;
    int cnt;
    int bad;
    for (int a = 1; a <= 3; a++) begin
      press(4'd1); press(4'd2); press(4'd3); press(4'd5);
      press(4'hA);
      exp_q.push_back(mk(16'h1235, 4'(a - 1), 1'b0, 1'b0, 1'b1));
      exp_q.push_back(mk(16'hFFFF, 4'(a), 1'b0, (a == 3), (a == 3)));
      exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) $display("FAIL wrong_check_%0d: got %h want %h", a, obs, exp_v); else passed++;
      @(negedge clk);
      exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) $display("FAIL wrong_result_%0d: got %h want %h", a, obs, exp_v); else passed++;
    end
    cnt = 0;
    bad = 0;
    while (alarm === 1'b1 && cnt < 500) begin
      cnt++;
      if (obs !== mk(16'hFFFF, 4'd3, 1'b0, 1'b1, 1'b1)) bad++;
      key_valid = 1'b1;
      key_code  = 4'($urandom_range(0, 10));
      @(negedge clk);
    end
    key_valid = 1'b0;
    total++;
    if (cnt !== int'(LCK)) $display("FAIL alarm_width: got %0d want %0d", cnt, LCK); else passed++;
    total++;
    if (bad !== 0) $display("FAIL locked_keys_ignored: got %0d disturbed cycles want 0", bad); else passed++;
    @(negedge clk);
    exp_q.push_back(mk(16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL lockout_done: got %h want %h", obs, exp_v); else passed++;
  endtask

  task automatic test_clear;
    press(4'd7); press(4'd8);
    exp_q.push_back(mk(16'h78FF, 4'd0, 1'b0, 1'b0, 1'b0));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL clear_pre: got %h want %h", obs, exp_v); else passed++;
    press(4'hB);
    exp_q.push_back(mk(16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL clear_blank: got %h want %h", obs, exp_v); else passed++;
    press(4'd9);
    exp_q.push_back(mk(16'h9FFF, 4'd0, 1'b0, 1'b0, 1'b0));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL clear_then_digit: got %h want %h", obs, exp_v); else passed++;
    press(4'hB);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    exp_q.push_back(mk(16'h1234, 4'd0, 1'b0, 1'b0, 1'b0));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL fifth_digit: got %h want %h", obs, exp_v); else passed++;
    press(4'hB);
  endtask

  task automatic test_short_enter;
    press(4'd1); press(4'd1); press(4'd1); press(4'd1); press(4'hA);
    @(negedge clk);
    exp_q.push_back(mk(16'hFFFF, 4'd1, 1'b0, 1'b0, 1'b0));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL one_wrong: got %h want %h", obs, exp_v); else passed++;
    press(4'd1); press(4'd2); press(4'hA);
    exp_q.push_back(mk(16'h12FF, 4'd1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(16'h12FF, 4'd1, 1'b0, 1'b0, 1'b0));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL short_enter: got %h want %h", obs, exp_v); else passed++;
    @(negedge clk);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL short_enter_hold: got %h want %h", obs, exp_v); else passed++;
    press(4'hB);
  endtask

  task automatic test_reset_open;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hA);
    repeat (4) @(negedge clk);
    exp_q.push_back(mk(16'hFFFF, 4'd0, 1'b1, 1'b0, 1'b1));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL open_before_reset: got %h want %h", obs, exp_v); else passed++;
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL async_reset_open: got %h want %h", obs, exp_v); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef LOCK_PWD_CHANGE_EN
  task automatic test_pwd_change;
    int cnt;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hA);
    @(negedge clk);
    press(4'hC);
    exp_q.push_back(mk(16'hFFFF, 4'd0, 1'b1, 1'b0, 1'b0));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL set_entered: got %h want %h", obs, exp_v); else passed++;
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    exp_q.push_back(mk(16'h9876, 4'd0, 1'b1, 1'b0, 1'b0));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL set_digits: got %h want %h", obs, exp_v); else passed++;
    press(4'hA);
    exp_q.push_back(mk(16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL set_commit: got %h want %h", obs, exp_v); else passed++;
    press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(4'hA);
    @(negedge clk);
    exp_q.push_back(mk(16'hFFFF, 4'd0, 1'b1, 1'b0, 1'b1));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL new_pwd_unlock: got %h want %h", obs, exp_v); else passed++;
    cnt = 0;
    while (unlock === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hA);
    @(negedge clk);
    exp_q.push_back(mk(16'hFFFF, 4'd1, 1'b0, 1'b0, 1'b0));
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL old_pwd_wrong: got %h want %h", obs, exp_v); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_clear();
    test_short_enter();
    test_reset_open();
`ifdef LOCK_PWD_CHANGE_EN
    test_pwd_change();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
